// File: rtl/spi_mem_slave_if.sv
// spi_mem_slave_if: serial link between the SPI master and the memory responder.
//
// Signals
//   cs       master -> slave  chip select, active low
//   mosi     master -> slave  serial frame data, LSB first
//   miso     slave  -> master serial read data, LSB first
//   ready    slave  -> master one-cycle pulse; read byte follows on miso
//   op_done  slave  -> master one-cycle pulse; write frame committed
//
// Handshake: there is no backpressure on this link. A frame is framed by cs
// low; the responder consumes one mosi bit per clock after a one-cycle skip.
// ready and op_done are single-cycle strobes that the master must observe on
// the cycle they are high; ready is followed immediately by eight miso bits.
interface spi_mem_slave_if;
  logic cs;
  logic mosi;
  logic miso;
  logic ready;
  logic op_done;

  modport master (
    output cs,
    output mosi,
    input  miso,
    input  ready,
    input  op_done
  );

  modport slave (
    input  cs,
    input  mosi,
    output miso,
    output ready,
    output op_done
  );
endinterface

// File: rtl/spi_mem_slave.sv
// spi_mem_slave: serial memory responder on the far end of the SPI master link.
//
// Deserializes frames from mosi while cs is low and stores bytes in a
// DEPTH x 8 register array.
//   Write frame (17 bits): bit0=1, bits1-8 addr[7:0], bits9-16 data[7:0]
//   Read frame  (8 bits) : bit0=0, bits1-7 addr[6:0]
// A read answers with a one-cycle ready pulse followed by eight data bits on
// miso, LSB first. Out-of-range writes are dropped (op_done still pulses),
// out-of-range reads return 0x00.
//
// Ports
//   clk          single clock, rising edge
//   rstn         asynchronous active-low reset (clears memory too)
//   bus          spi_mem_slave_if.slave (cs, mosi, miso, ready, op_done)
//   o_dbg_state  current FSM state, for observation only
module spi_mem_slave #(
  parameter int DEPTH = 32
) (
  input  logic              clk,
  input  logic              rstn,
  spi_mem_slave_if.slave    bus,
  output logic [2:0]        o_dbg_state
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GET_MODE = 3'd1;
  localparam logic [2:0] RX_WRITE = 3'd2;
  localparam logic [2:0] COMMIT   = 3'd3;
  localparam logic [2:0] RX_ADDR  = 3'd4;
  localparam logic [2:0] FETCH    = 3'd5;
  localparam logic [2:0] TX       = 3'd6;

  logic [2:0]  r_state;
  logic [4:0]  r_cnt;
  logic [15:0] r_shift;
  logic [7:0]  r_tx;
  logic        r_miso;
  logic        r_ready;
  logic        r_op_done;
  logic [7:0]  r_mem [DEPTH];

  logic [7:0]    w_addr;
  logic [7:0]    w_data;
  logic          w_in_range;
  logic [AW-1:0] w_idx;

  // The write frame carries an 8-bit address in shift[7:0]; the read frame
  // only 7 bits, landing in shift[6:0] and zero-extended.
  assign w_addr     = (r_state == COMMIT) ? r_shift[7:0] : {1'b0, r_shift[6:0]};
  assign w_data     = r_shift[15:8];
  assign w_in_range = ({1'b0, w_addr} < DEPTH_W);
  assign w_idx      = w_addr[AW-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_tx      <= '0;
      r_miso    <= 1'b0;
      r_ready   <= 1'b0;
      r_op_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // Strobes are high for exactly the one cycle after the state that sets them.
      r_ready   <= 1'b0;
      r_op_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_miso <= 1'b0;
          r_cnt  <= '0;
          // The edge that first sees cs low carries stale mosi; it is the skip cycle.
          if (!bus.cs) begin
            r_state <= GET_MODE;
          end
        end
        GET_MODE: begin
          r_cnt   <= '0;
          r_shift <= '0;
          if (bus.cs) begin
            r_state <= IDLE;
          end else begin
            r_state <= bus.mosi ? RX_WRITE : RX_ADDR;
          end
        end
        RX_WRITE: begin
          if (bus.cs) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_shift[r_cnt[3:0]] <= bus.mosi;
            if (r_cnt == 5'd15) begin
              r_cnt   <= '0;
              r_state <= COMMIT;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        COMMIT: begin
          if (w_in_range) begin
            r_mem[w_idx] <= w_data;
          end
          r_op_done <= 1'b1;
          r_cnt     <= '0;
          r_state   <= IDLE;
        end
        RX_ADDR: begin
          if (bus.cs) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_shift[r_cnt[3:0]] <= bus.mosi;
            if (r_cnt == 5'd6) begin
              r_cnt   <= '0;
              r_state <= FETCH;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
          end
        end
        FETCH: begin
          r_tx    <= w_in_range ? r_mem[w_idx] : 8'h00;
          r_ready <= 1'b1;
          r_cnt   <= '0;
          r_state <= TX;
        end
        TX: begin
          // Counts 0..7 drive data bits; count 8 parks miso low and finishes.
          if (r_cnt == 5'd8) begin
            r_miso  <= 1'b0;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_miso <= r_tx[r_cnt[2:0]];
            r_cnt  <= r_cnt + 5'd1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.miso    = r_miso;
  assign bus.ready   = r_ready;
  assign bus.op_done = r_op_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_mem_slave.sv
module tb_spi_mem_slave;

  localparam logic [2:0]  ST_IDLE     = 3'd0;
  localparam logic [2:0]  ST_RX_WRITE = 3'd2;
  localparam logic [19:0] DONE_MASK   = 20'h40000; // op_done after edge N+19
  localparam logic [19:0] READY_MASK  = 20'h00200; // ready after edge N+10

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  spi_mem_slave_if bus ();
  logic [2:0] dbg_state;

  spi_mem_slave #(.DEPTH(32)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_mem [32];

  // Observations of the most recent frame, indexed by j where bit j is the
  // value seen after edge N+1+j.
  logic [19:0] obs_done;
  logic [19:0] obs_ready;
  logic [7:0]  obs_rx;
  logic        obs_miso_end;

  // ---------------- driver tasks ----------------
  // Called at a negedge. abort_at >= 0 raises cs once that many bits were sent.
  // chain keeps cs low on edge N+19 so the next frame starts at minimum gap.
  task automatic drive_frame(input logic is_wr, input logic [7:0] addr,
                             input logic [7:0] data, input int abort_at,
                             input logic chain);
    logic [16:0] bits;
    int nbits;
    int last_j;
    int k;
    bits   = is_wr ? {data, addr, 1'b1} : {9'b0, addr[6:0], 1'b0};
    nbits  = is_wr ? 17 : 8;
    last_j = chain ? 18 : 19;
    obs_done     = '0;
    obs_ready    = '0;
    obs_rx       = '0;
    obs_miso_end = 1'b0;
    for (int j = 0; j <= last_j; j++) begin
      k = j - 1;
      if (j == 0) begin
        bus.cs   = 1'b0;
        bus.mosi = 1'($urandom_range(0, 1));
      end else if (k < nbits && (abort_at < 0 || k < abort_at)) begin
        bus.cs   = 1'b0;
        bus.mosi = bits[k];
      end else begin
        bus.cs   = (chain && j == last_j) ? 1'b0 : 1'b1;
        bus.mosi = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      obs_done[j]  = bus.op_done;
      obs_ready[j] = bus.ready;
      if (j >= 10 && j <= 17) obs_rx[j-10] = bus.miso;
      if (j == 18) obs_miso_end = bus.miso;
    end
  endtask

  task automatic send_write(input logic [7:0] addr, input logic [7:0] data,
                            input int abort_at, input logic chain);
    if (abort_at < 0 && addr < 8'd32) model_mem[addr[4:0]] = data;
    drive_frame(1'b1, addr, data, abort_at, chain);
  endtask

  task automatic send_read(input logic [7:0] addr, input logic chain);
    logic [6:0] a7;
    a7 = addr[6:0];
    exp_q.push_back((a7 < 7'd32) ? model_mem[a7[4:0]] : 8'h00);
    drive_frame(1'b0, addr, 8'h00, -1, chain);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [7:0] got;
    logic [7:0] exp;
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;
    rstn     = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.miso, bus.ready, bus.op_done, dbg_state} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected %b",
               {bus.miso, bus.ready, bus.op_done, dbg_state}, 6'b0);
    end
    rstn = 1'b1;
    @(negedge clk);

    // Put something in memory so the mid-frame reset has a visible effect.
    send_write(8'd7, 8'h5A, -1, 1'b0);
    checks++;
    if (obs_done !== DONE_MASK) begin
      failures++;
      $display("FAIL reset_prewrite_done: got %h expected %h", obs_done, DONE_MASK);
    end

    // Start a write frame and reset it partway through RX_WRITE.
    bus.cs = 1'b0; bus.mosi = 1'b0; @(negedge clk);
    bus.mosi = 1'b1;                @(negedge clk);
    bus.mosi = 1'b1;                @(negedge clk);
    bus.mosi = 1'b0;                @(negedge clk);
    checks++;
    if (dbg_state !== ST_RX_WRITE) begin
      failures++;
      $display("FAIL reset_in_rx_write: got %0d expected %0d", dbg_state, ST_RX_WRITE);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({bus.miso, bus.ready, bus.op_done, dbg_state} !== 6'b0) begin
      failures++;
      $display("FAIL reset_midframe_outputs: got %b expected %b",
               {bus.miso, bus.ready, bus.op_done, dbg_state}, 6'b0);
    end
    bus.cs = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;

    for (int i = 0; i < 32; i++) begin
      send_read(8'(i), 1'b0);
      got = obs_rx;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reset_read_addr%0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_write_read();
    logic [7:0] exp;
    send_write(8'd3, 8'hA5, -1, 1'b0);
    checks++;
    if (obs_done !== DONE_MASK || obs_ready !== 20'h0) begin
      failures++;
      $display("FAIL wr_op_done_pulse: got done=%h ready=%h expected done=%h ready=0",
               obs_done, obs_ready, DONE_MASK);
    end
    send_read(8'd3, 1'b0);
    checks++;
    if (obs_ready !== READY_MASK || obs_done !== 20'h0) begin
      failures++;
      $display("FAIL rd_ready_pulse: got ready=%h done=%h expected ready=%h done=0",
               obs_ready, obs_done, READY_MASK);
    end
    checks++;
    if (obs_rx !== 8'hA5) begin
      failures++;
      $display("FAIL rd_miso_bits: got %b expected %b (LSB first from N+11)", obs_rx, 8'hA5);
    end
    exp = exp_q.pop_front();
    checks++;
    if (obs_rx !== exp) begin
      failures++;
      $display("FAIL rd_scoreboard: got %h expected %h", obs_rx, exp);
    end
    checks++;
    if (obs_miso_end !== 1'b0) begin
      failures++;
      $display("FAIL rd_miso_tail: got %b expected 0", obs_miso_end);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp;
    for (int i = 0; i < 32; i++) begin
      send_write(8'(i), 8'hFF - 8'(i), -1, 1'b0);
      checks++;
      if (obs_done !== DONE_MASK) begin
        failures++;
        $display("FAIL sweep_wr_done%0d: got %h expected %h", i, obs_done, DONE_MASK);
      end
    end
    for (int i = 0; i < 32; i++) begin
      send_read(8'(i), 1'b0);
      exp = exp_q.pop_front();
      checks++;
      if (obs_rx !== exp) begin
        failures++;
        $display("FAIL sweep_rd%0d: got %h expected %h", i, obs_rx, exp);
      end
    end
    send_write(8'd31, 8'h00, -1, 1'b0);
    send_read(8'd31, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (obs_rx !== exp) begin
      failures++;
      $display("FAIL sweep_addr31_zero: got %h expected %h", obs_rx, exp);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] exp;
    send_write(8'd40, 8'h77, -1, 1'b0);
    checks++;
    if (obs_done !== DONE_MASK) begin
      failures++;
      $display("FAIL oor_wr_done: got %h expected %h", obs_done, DONE_MASK);
    end
    // addr 8 shares the low index bits with 40; it must be untouched.
    send_read(8'd8, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (obs_rx !== exp) begin
      failures++;
      $display("FAIL oor_no_alias: got %h expected %h", obs_rx, exp);
    end
    send_read(8'd40, 1'b0);
    checks++;
    if (obs_ready !== READY_MASK) begin
      failures++;
      $display("FAIL oor_rd_ready: got %h expected %h", obs_ready, READY_MASK);
    end
    exp = exp_q.pop_front();
    checks++;
    if (obs_rx !== exp) begin
      failures++;
      $display("FAIL oor_rd_data: got %h expected %h", obs_rx, exp);
    end
  endtask

  task automatic test_abort();
    logic [7:0] exp;
    send_write(8'd5, 8'h11, 7, 1'b0);
    checks++;
    if (obs_done !== 20'h0 || obs_ready !== 20'h0) begin
      failures++;
      $display("FAIL abort_no_strobe: got done=%h ready=%h expected 0", obs_done, obs_ready);
    end
    checks++;
    if (dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL abort_idle: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    send_read(8'd5, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (obs_rx !== exp) begin
      failures++;
      $display("FAIL abort_retained: got %h expected %h", obs_rx, exp);
    end
    send_write(8'd5, 8'h11, -1, 1'b0);
    checks++;
    if (obs_done !== DONE_MASK) begin
      failures++;
      $display("FAIL abort_next_done: got %h expected %h", obs_done, DONE_MASK);
    end
    send_read(8'd5, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (obs_rx !== exp) begin
      failures++;
      $display("FAIL abort_next_read: got %h expected %h", obs_rx, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    for (int p = 0; p < 6; p++) begin
      a = 8'($urandom_range(0, 31));
      d = 8'($urandom_range(0, 255));
      send_write(a, d, -1, 1'b1);
      checks++;
      if (obs_done !== DONE_MASK || obs_ready !== 20'h0) begin
        failures++;
        $display("FAIL b2b_wr%0d: got done=%h ready=%h expected done=%h ready=0",
                 p, obs_done, obs_ready, DONE_MASK);
      end
      send_read(a, (p != 5));
      checks++;
      if (obs_ready !== READY_MASK || obs_done !== 20'h0) begin
        failures++;
        $display("FAIL b2b_rd_ready%0d: got ready=%h done=%h expected ready=%h done=0",
                 p, obs_ready, obs_done, READY_MASK);
      end
      exp = exp_q.pop_front();
      checks++;
      if (obs_rx !== exp) begin
        failures++;
        $display("FAIL b2b_rd_data%0d: got %h expected %h", p, obs_rx, exp);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
    bus.cs   = 1'b1;
    bus.mosi = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_sweep();
    test_out_of_range();
    test_abort();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_mem_slave.md
# spi_mem_slave

Serial memory responder at the far end of the SPI master link. It deserializes write and read frames from `mosi` while `cs` is low. It stores bytes in a 32-entry by 8-bit register array and answers reads by pulsing `ready` and then shifting the byte out on `miso`. It sits beside the SPI master in the SPI memory subsystem and is the DUT partner for master-level tests.

## Interface
- `DEPTH`, default 32: number of 8-bit memory words. Index width is $clog2(DEPTH).
- `clk`  input  1: single clock; all sampling and driving happen on its rising edge.
- `rstn`  input  1: asynchronous, active-low reset.
- `cs`  input  1: chip select, active low, driven from a register in the master.
- `mosi`  input  1: serial data from the master, LSB first.
- `miso`  output  1: serial read data to the master, LSB first.
- `ready`  output  1: one-cycle pulse; read data follows on `miso`.
- `op_done`  output  1: one-cycle pulse; a write frame has been committed.

## Operation
- Write frame: 17 bits.
  - bit0 = 1 (wr).
  - bits1–8 = addr[7:0].
  - bits9–16 = data[7:0].
- Read frame: 8 bits.
  - bit0 = 0.
  - bits1–7 = addr[6:0].
- First-bit skip: on the first edge `cs` is seen low, `mosi` is stale. That cycle is skipped and bit0 is sampled on the following edge.
- State `IDLE`:
  - Outputs are 0.
  - When `cs`=0, go to `GET_MODE`.
- State `GET_MODE`:
  - Sample `mosi` as wr.
  - wr=1: go to `RX_WRITE`. wr=0: go to `RX_ADDR`.
- State `RX_WRITE`:
  - Shift in 16 bits, one per cycle, into a 16-bit shift register at positions LSB-first.
  - After the 16th bit, go to `COMMIT`.
- State `COMMIT` (1 cycle):
  - If addr < DEPTH, write `mem[addr]` = data. Otherwise drop the write.
  - In both cases set `op_done`=1, then go to `IDLE`.
- State `RX_ADDR`:
  - Shift in 7 address bits, zero-extended to 8 bits.
  - After the 7th bit, go to `FETCH`.
- State `FETCH` (1 cycle):
  - Latch `mem[addr]` into an 8-bit TX register, or 0x00 if addr ≥ DEPTH.
  - Set `ready`=1, then go to `TX`.
- State `TX`: lasts 8 cycles.
  - On entry edge k (k = 0..7), `miso` <= tx[k] and `ready` <= 0.
  - After bit7 has been driven for one cycle, `miso` <= 0 and go to `IDLE`.
- `cs` is ignored in `COMMIT`, `FETCH` and `TX`, because the master has already raised it.
- `cs` = 1 while in `GET_MODE`, `RX_WRITE` or `RX_ADDR` is an abort:
  - Return to `IDLE` on that edge.
  - No memory write, no `op_done`, no `ready`.
  - Partial shift contents are discarded.
- Frame counter: 5-bit, cleared on every entry to `IDLE`. It never wraps within a frame.

## Timing
- Reset values:
  - `miso`=0, `ready`=0, `op_done`=0.
  - State = `IDLE`, counter = 0.
  - All memory words = 0x00.
  - Reset asserted mid-frame discards the frame immediately; memory is cleared.
- Edge numbering: edge N+1 is the first edge with `cs`=0 observed.
- Write frame:
  - bitk of the frame is sampled at edge N+2+k, so bit16 is sampled at N+18.
  - `COMMIT` at N+19: the memory is updated and `op_done` goes high.
  - `op_done` drops at N+20, when the block is back in `IDLE`.
- Read frame:
  - bit0 is sampled at N+2 and addr bits at N+3..N+9.
  - `FETCH` at N+10: `ready` goes high.
  - At N+11, `ready` goes low and `miso` = data bit0.
  - `miso` = bitk from N+11+k, so bit7 is driven at N+18.
  - At N+19, `miso` = 0 and the state is `IDLE`.
  - The master samples bitk at N+12+k.
- Back-to-back: a new `cs`-low seen on the edge the block returns to `IDLE` is accepted with the normal skip cycle.
- Read-after-write to the same address returns the new data. The write commits several cycles before the next frame can start.

## Test plan
- Reset:
  - Stimulus: assert `rstn`=0 mid-`RX_WRITE`, then release.
  - Required: all outputs 0; reads of addresses 0–31 return 0x00.
- Write then read:
  - Stimulus: write 0xA5 to addr 3.
  - Required: `op_done` is a single pulse at N+19.
  - Stimulus: read addr 3.
  - Required: `ready` pulses at N+10; `miso` carries 1,0,1,0,0,1,0,1 (LSB first); the master `dout` = 0xA5.
- Sweep:
  - Stimulus: write addr i with data 8'hFF−i for i = 0..31, then read all 32 back.
  - Required: every value matches.
  - Stimulus: write 0x00 to addr 31, then read addr 31.
  - Required: 0x00 returned.
- Out of range:
  - Stimulus: directly driven write frame, addr 40, data 0x77.
  - Required: `op_done` pulses; memory is unchanged.
  - Stimulus: read addr 40 (7-bit field).
  - Required: `ready` pulses and 0x00 is shifted out.
- Abort:
  - Stimulus: raise `cs` after bit 6 of a write frame to addr 5.
  - Required: no `op_done`; addr 5 retains its old value; the next full frame is processed normally.
- Back-to-back:
  - Stimulus: alternating write/read pairs with the master at minimum gap.
  - Required: no missed frames; every `ready` and `op_done` is exactly one cycle wide.
